// File: rtl/program_loader.sv
// program_loader
//
// Upstream feeder for the multi-cycle core. Parses a framed byte stream
//   0xA5, N, {hi, lo} x N, [checksum]
// and writes N 16-bit instruction words into instruction memory starting
// at address 0. The core is held in reset until a complete image has been
// written, and is then released.
//
// Optional feature macro: LOADER_CSUM_EN
//   defined   : a trailing checksum byte (XOR of all 2N data bytes) is
//               expected and checked before RUN; a mismatch gives err_code 2.
//   undefined : the last WRITE goes straight to RUN and no checksum byte
//               is expected.
//
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready.
// rx_ready is decoded from state; it is low only in WRITE and RUN.
// load_req wins over a simultaneous byte, which is then dropped.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   rx_data      incoming byte
//   rx_valid     rx_data valid
//   rx_ready     loader accepts a byte this cycle
//   load_req     one-cycle pulse: abort / restart and wait for a new frame
//   imem_wr_en   instruction memory write strobe (one cycle per word)
//   imem_addr    write address (word index)
//   imem_wr_data write word {hi, lo}
//   core_rst_n   active-low core reset, high only in RUN (registered)
//   done         high in RUN (registered)
//   error        high in ERR (registered)
//   err_code     0 none, 1 bad count, 2 checksum, 3 timeout
//   state_dbg    current FSM state encoding
module program_loader #(
  parameter int INSTRUCTION_LEN = 16,
  parameter int ADDR_LEN        = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  input  logic                       load_req,
  output logic                       imem_wr_en,
  output logic [ADDR_LEN-1:0]        imem_addr,
  output logic [INSTRUCTION_LEN-1:0] imem_wr_data,
  output logic                       core_rst_n,
  output logic                       done,
  output logic                       error,
  output logic [1:0]                 err_code,
  output logic [2:0]                 state_dbg
);

  // Wide enough to hold both the byte count and 2^ADDR_LEN.
  localparam int CW = ((ADDR_LEN > 8) ? ADDR_LEN : 8) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_WAIT_HDR = 3'd0,
    S_GET_CNT  = 3'd1,
    S_GET_HI   = 3'd2,
    S_GET_LO   = 3'd3,
    S_WRITE    = 3'd4,
    S_GET_CSUM = 3'd5,
    S_RUN      = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  state_t              state, state_next;
  logic [1:0]          err_next;
  logic [7:0]          cnt_q;
  logic [ADDR_LEN-1:0] idx;
  logic [7:0]          hi_q, lo_q;
  logic [TW-1:0]       tmo_cnt;
  logic                accept, take, timed, tmo_hit, last_word, cnt_bad, hdr_start;
`ifdef LOADER_CSUM_EN
  logic [7:0]          acc;
`endif

  assign rx_ready  = (state != S_WRITE) && (state != S_RUN);
  assign accept    = rx_valid && rx_ready;
  // A byte coinciding with load_req is dropped.
  assign take      = accept && !load_req;
  assign timed     = (state == S_GET_CNT) || (state == S_GET_HI) ||
                     (state == S_GET_LO)  || (state == S_GET_CSUM);
  // The TIMEOUT_CYCLES-th consecutive idle edge fires; a byte on that edge wins.
  assign tmo_hit   = timed && !accept && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign last_word = (CW'(idx) + CW'(1)) == CW'(cnt_q);
  assign cnt_bad   = (rx_data == 8'd0) || (CW'(rx_data) > (CW'(1) << ADDR_LEN));
  assign hdr_start = take && (rx_data == SYNC) &&
                     ((state == S_WAIT_HDR) || (state == S_ERR));

  assign imem_wr_en   = (state == S_WRITE);
  assign imem_addr    = idx;
  assign imem_wr_data = {hi_q, lo_q};
  assign state_dbg    = state;

  always_comb begin
    state_next = state;
    err_next   = 2'd0;
    if (load_req) begin
      state_next = S_WAIT_HDR;
    end else begin
      case (state)
        S_WAIT_HDR: if (accept && rx_data == SYNC) state_next = S_GET_CNT;
        S_GET_CNT: begin
          if (accept) begin
            if (cnt_bad) begin
              state_next = S_ERR;
              err_next   = 2'd1;
            end else begin
              state_next = S_GET_HI;
            end
          end else if (tmo_hit) begin
            state_next = S_ERR;
            err_next   = 2'd3;
          end
        end
        S_GET_HI: begin
          if (accept) state_next = S_GET_LO;
          else if (tmo_hit) begin
            state_next = S_ERR;
            err_next   = 2'd3;
          end
        end
        S_GET_LO: begin
          if (accept) state_next = S_WRITE;
          else if (tmo_hit) begin
            state_next = S_ERR;
            err_next   = 2'd3;
          end
        end
        S_WRITE: begin
          if (last_word) begin
`ifdef LOADER_CSUM_EN
            state_next = S_GET_CSUM;
`else
            state_next = S_RUN;
`endif
          end else begin
            state_next = S_GET_HI;
          end
        end
`ifdef LOADER_CSUM_EN
        S_GET_CSUM: begin
          if (accept) begin
            if (rx_data == acc) state_next = S_RUN;
            else begin
              state_next = S_ERR;
              err_next   = 2'd2;
            end
          end else if (tmo_hit) begin
            state_next = S_ERR;
            err_next   = 2'd3;
          end
        end
`endif
        S_RUN: state_next = S_RUN;
        S_ERR: if (accept && rx_data == SYNC) state_next = S_GET_CNT;
        default: state_next = S_WAIT_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_WAIT_HDR;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
      cnt_q      <= 8'd0;
      idx        <= '0;
      hi_q       <= 8'd0;
      lo_q       <= 8'd0;
      tmo_cnt    <= '0;
`ifdef LOADER_CSUM_EN
      acc        <= 8'd0;
`endif
    end else begin
      state      <= state_next;
      // Status flags follow the next state so they move on the transition edge.
      core_rst_n <= (state_next == S_RUN);
      done       <= (state_next == S_RUN);
      error      <= (state_next == S_ERR);
      if (state_next == S_ERR) begin
        if (state != S_ERR) err_code <= err_next;
      end else begin
        err_code <= 2'd0;
      end

      if (!timed || take || (state_next != state)) tmo_cnt <= '0;
      else                                          tmo_cnt <= tmo_cnt + TW'(1);

      if (hdr_start) idx <= '0;
      // Stop at N-1 so the index never walks past the image.
      else if (state == S_WRITE && !last_word) idx <= idx + 1'b1;

      if (take && state == S_GET_CNT && !cnt_bad) cnt_q <= rx_data;
      if (take && state == S_GET_HI) hi_q <= rx_data;
      if (take && state == S_GET_LO) lo_q <= rx_data;
`ifdef LOADER_CSUM_EN
      if (hdr_start) acc <= 8'd0;
      else if (take && (state == S_GET_HI || state == S_GET_LO)) acc <= acc ^ rx_data;
`endif
    end
  end

endmodule
